// File: rtl/shape_move_scheduler_if.sv
// Host absolute-position load port of shape_move_scheduler.
`timescale 1ns/1ps
interface shape_move_scheduler_if;
  logic       iHostValid;
  logic [9:0] iHostX;
  logic [9:0] iHostY;
  logic       oHostReady;

  modport master (output iHostValid, iHostX, iHostY, input oHostReady);
  modport slave  (input iHostValid, iHostX, iHostY, output oHostReady);
endinterface

// File: rtl/shape_move_scheduler.sv
// Arbitrates host loads, push-button moves and the bouncing screensaver onto one clamped
// shape position. Define SHAPE_SCHED_HOST_EN to build the host load port.
`timescale 1ns/1ps
module shape_move_scheduler #(
  parameter int TICK_DIV   = 100000,
  parameter int X_MAX      = 580,
  parameter int Y_MAX      = 420,
  parameter int X_DEFAULT  = 290,
  parameter int Y_DEFAULT  = 210,
  parameter int SHAPE_SIZE = 60
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iPushUp,
  input  logic                  iPushDown,
  input  logic                  iPushLeft,
  input  logic                  iPushRight,
  input  logic                  iSaverEn,
  shape_move_scheduler_if.slave host,
  output logic [9:0]            oShapeX,
  output logic [9:0]            oShapeY,
  output logic [9:0]            oShapeSize,
  output logic [2:0]            oGrant,
  output logic                  oLEDUp,
  output logic                  oLEDDown,
  output logic                  oLEDLeft,
  output logic                  oLEDRight
);
  localparam int              CntW     = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] TickLast = CntW'(TICK_DIV - 1);
  localparam logic [9:0]      XMax     = 10'(X_MAX);
  localparam logic [9:0]      YMax     = 10'(Y_MAX);

  localparam logic [1:0] sIdle   = 2'd0;
  localparam logic [1:0] sManual = 2'd1;
  localparam logic [1:0] sSaver  = 2'd2;

  logic [1:0]      state, nextState;
  logic [CntW-1:0] tickCnt;
  logic            tick, loadTaken, hostPulse, entering;
  logic [9:0]      posX, posY, stepX, stepY, nextX, nextY;
  logic            dirX, dirY, stepDirX, stepDirY;

`ifdef SHAPE_SCHED_HOST_EN
  logic hostReady;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      hostReady <= 1'b0;
      hostPulse <= 1'b0;
    end else begin
      hostReady <= 1'b1;
      hostPulse <= loadTaken;
    end
  end

  assign host.oHostReady = hostReady;
  assign loadTaken       = host.iHostValid & hostReady;
`else
  logic unusedHost;
  assign unusedHost      = ^{host.iHostValid, host.iHostX, host.iHostY};
  assign host.oHostReady = 1'b0;
  assign loadTaken       = 1'b0;
  assign hostPulse       = 1'b0;
`endif

  assign tick     = (tickCnt == TickLast);
  assign entering = (nextState == sSaver) && (state != sSaver);

  // Pushes always win over the saver; evaluated every cycle.
  always_comb begin
    nextState = sIdle;
    if (iPushUp | iPushDown | iPushLeft | iPushRight)
      nextState = sManual;
    else if (iSaverEn)
      nextState = sSaver;
  end

  always_comb begin
    stepX    = posX;
    stepY    = posY;
    stepDirX = dirX;
    stepDirY = dirY;
    if (tick && state == sManual) begin
      if (iPushUp) begin
        if (posY != 10'd0) stepY = posY - 10'd1;
      end else if (iPushDown) begin
        if (posY < YMax) stepY = posY + 10'd1;
      end else if (iPushLeft) begin
        if (posX != 10'd0) stepX = posX - 10'd1;
      end else if (iPushRight) begin
        if (posX < XMax) stepX = posX + 10'd1;
      end
    end else if (tick && state == sSaver) begin
      // A boundary hit reverses direction and steps back in the same tick.
      if (dirX) begin
        if (posX >= XMax) begin
          stepDirX = 1'b0;
          stepX    = posX - 10'd1;
        end else begin
          stepX = posX + 10'd1;
        end
      end else begin
        if (posX == 10'd0) begin
          stepDirX = 1'b1;
          stepX    = posX + 10'd1;
        end else begin
          stepX = posX - 10'd1;
        end
      end
      if (dirY) begin
        if (posY >= YMax) begin
          stepDirY = 1'b0;
          stepY    = posY - 10'd1;
        end else begin
          stepY = posY + 10'd1;
        end
      end else begin
        if (posY == 10'd0) begin
          stepDirY = 1'b1;
          stepY    = posY + 10'd1;
        end else begin
          stepY = posY - 10'd1;
        end
      end
    end
  end

  always_comb begin
    nextX = stepX;
    nextY = stepY;
`ifdef SHAPE_SCHED_HOST_EN
    if (loadTaken) begin
      nextX = (host.iHostX > XMax) ? XMax : host.iHostX;
      nextY = (host.iHostY > YMax) ? YMax : host.iHostY;
    end
`endif
  end

  // A host load drops the coincident step and restarts the tick interval.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state   <= sIdle;
      tickCnt <= '0;
      posX    <= 10'(X_DEFAULT);
      posY    <= 10'(Y_DEFAULT);
      dirX    <= 1'b1;
      dirY    <= 1'b1;
    end else begin
      state   <= nextState;
      tickCnt <= (tick || loadTaken) ? '0 : tickCnt + CntW'(1);
      posX    <= nextX;
      posY    <= nextY;
      if (entering) begin
        dirX <= 1'b1;
        dirY <= 1'b1;
      end else if (!loadTaken) begin
        dirX <= stepDirX;
        dirY <= stepDirY;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oLEDUp    <= 1'b0;
      oLEDDown  <= 1'b0;
      oLEDLeft  <= 1'b0;
      oLEDRight <= 1'b0;
    end else begin
      oLEDUp    <= (nextState == sSaver) | iPushUp;
      oLEDDown  <= (nextState == sSaver) | (iPushDown & ~iPushUp);
      oLEDLeft  <= (nextState == sSaver) | (iPushLeft & ~iPushUp & ~iPushDown);
      oLEDRight <= (nextState == sSaver) | (iPushRight & ~iPushUp & ~iPushDown & ~iPushLeft);
    end
  end

  always_comb begin
    oGrant = 3'b000;
    if (hostPulse)
      oGrant = 3'b100;
    else if (state == sManual)
      oGrant = 3'b010;
    else if (state == sSaver)
      oGrant = 3'b001;
  end

  assign oShapeX    = posX;
  assign oShapeY    = posY;
  assign oShapeSize = 10'(SHAPE_SIZE);
endmodule

// File: tb/tb_shape_move_scheduler.sv
// Scoreboard bench for shape_move_scheduler: stimulus queues expected positions and a
// monitor pops one whenever the DUT position changes.
`timescale 1ns/1ps
module tb_shape_move_scheduler;
  localparam int TickDiv = 4;
  localparam int XMax    = 580;
  localparam int YMax    = 420;
`ifdef SHAPE_SCHED_HOST_EN
  localparam int HostEn = 1;
`else
  localparam int HostEn = 0;
`endif

  typedef struct {
    int x;
    int y;
  } posT;

  logic       iClk      = 1'b0;
  logic       iRstN     = 1'b0;
  logic       pushUp    = 1'b0;
  logic       pushDown  = 1'b0;
  logic       pushLeft  = 1'b0;
  logic       pushRight = 1'b0;
  logic       saverEn   = 1'b0;
  logic [9:0] shapeX, shapeY, shapeSize;
  logic [2:0] grant;
  logic       ledUp, ledDown, ledLeft, ledRight;

  shape_move_scheduler_if hostIf();

  posT  expQ[$];
  int   checks    = 0;
  int   passes    = 0;
  int   modelX    = 290;
  int   modelY    = 210;
  logic modelDirX = 1'b1;
  logic modelDirY = 1'b1;
  bit   monitorOn = 1'b0;

  always #5 iClk = ~iClk;

  shape_move_scheduler #(
    .TICK_DIV(TickDiv), .X_MAX(XMax), .Y_MAX(YMax),
    .X_DEFAULT(290), .Y_DEFAULT(210), .SHAPE_SIZE(60)
  ) dut (
    .iClk(iClk), .iRstN(iRstN),
    .iPushUp(pushUp), .iPushDown(pushDown), .iPushLeft(pushLeft), .iPushRight(pushRight),
    .iSaverEn(saverEn), .host(hostIf),
    .oShapeX(shapeX), .oShapeY(shapeY), .oShapeSize(shapeSize), .oGrant(grant),
    .oLEDUp(ledUp), .oLEDDown(ledDown), .oLEDLeft(ledLeft), .oLEDRight(ledRight)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic checkLeds(input string name, input int expected);
    checkOutput(name, int'({ledUp, ledDown, ledLeft, ledRight}), expected);
  endtask

  task automatic pushExp(input int x, input int y);
    posT p;
    p.x = x;
    p.y = y;
    expQ.push_back(p);
    modelX = x;
    modelY = y;
  endtask

  task automatic applyStimulus(input bit u, input bit d, input bit l, input bit r, input bit s);
    pushUp    = u;
    pushDown  = d;
    pushLeft  = l;
    pushRight = r;
    saverEn   = s;
  endtask

  // n ticks of manual motion: 4n+1 edges with the push held cover exactly n ticks.
  task automatic holdManual(input bit u, input bit d, input bit l, input bit r, input int n);
    int nx, ny;
    for (int t = 0; t < n; t++) begin
      nx = modelX;
      ny = modelY;
      if (u) begin
        if (ny > 0) ny--;
      end else if (d) begin
        if (ny < YMax) ny++;
      end else if (l) begin
        if (nx > 0) nx--;
      end else if (r) begin
        if (nx < XMax) nx++;
      end
      if (nx != modelX || ny != modelY) pushExp(nx, ny);
    end
    applyStimulus(u, d, l, r, 1'b0);
    repeat (4 * n + 1) @(negedge iClk);
    checkOutput("manualGrant", grant, 2);
    checkLeds("manualLeds", u ? 8 : d ? 4 : l ? 2 : 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge iClk);
  endtask

  task automatic saverModelStep();
    int nx, ny;
    if (modelDirX) begin
      if (modelX >= XMax) begin modelDirX = 1'b0; nx = modelX - 1; end
      else nx = modelX + 1;
    end else begin
      if (modelX == 0) begin modelDirX = 1'b1; nx = modelX + 1; end
      else nx = modelX - 1;
    end
    if (modelDirY) begin
      if (modelY >= YMax) begin modelDirY = 1'b0; ny = modelY - 1; end
      else ny = modelY + 1;
    end else begin
      if (modelY == 0) begin modelDirY = 1'b1; ny = modelY + 1; end
      else ny = modelY - 1;
    end
    pushExp(nx, ny);
  endtask

  task automatic waitSteps(input int n);
    int seen, cyc, lx, ly;
    seen = 0;
    cyc  = 0;
    lx   = shapeX;
    ly   = shapeY;
    while (seen < n && cyc < 4 * n + 8) begin
      @(negedge iClk);
      cyc++;
      if (shapeX != lx || shapeY != ly) begin
        seen++;
        lx = shapeX;
        ly = shapeY;
      end
    end
    checkOutput("saverStepCount", seen, n);
  endtask

  task automatic saverRun(input int n);
    modelDirX = 1'b1;
    modelDirY = 1'b1;
    for (int t = 0; t < n; t++) saverModelStep();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    waitSteps(n);
    checkOutput("saverGrant", grant, 1);
    checkLeds("saverLeds", 15);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge iClk);
    checkOutput("idleGrant", grant, 0);
    checkLeds("idleLeds", 0);
  endtask

`ifdef SHAPE_SCHED_HOST_EN
  task automatic hostLoad(input int x, input int y);
    checkOutput("hostReady", hostIf.oHostReady, 1);
    pushExp(x > XMax ? XMax : x, y > YMax ? YMax : y);
    hostIf.iHostValid = 1'b1;
    hostIf.iHostX     = 10'(x);
    hostIf.iHostY     = 10'(y);
    @(negedge iClk);
    hostIf.iHostValid = 1'b0;
    checkOutput("loadGrantPulse", grant, 4);
    @(negedge iClk);
    checkOutput("grantAfterPulse", grant, 0);
  endtask
`else
  task automatic hostAttempt(input int x, input int y);
    hostIf.iHostValid = 1'b1;
    hostIf.iHostX     = 10'(x);
    hostIf.iHostY     = 10'(y);
    repeat (2) @(negedge iClk);
    checkOutput("noHostReady", hostIf.oHostReady, 0);
    checkOutput("noHostGrant", grant, 0);
    hostIf.iHostValid = 1'b0;
    @(negedge iClk);
  endtask
`endif

  initial begin : monitor
    posT e;
    int  lastX, lastY;
    wait (monitorOn);
    lastX = shapeX;
    lastY = shapeY;
    forever begin
      @(negedge iClk);
      if (shapeX != lastX || shapeY != lastY) begin
        if (expQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpectedMove: got (%0d,%0d), expected no move from (%0d,%0d)",
                   shapeX, shapeY, lastX, lastY);
        end else begin
          e = expQ.pop_front();
          checkOutput("posX", shapeX, e.x);
          checkOutput("posY", shapeY, e.y);
        end
        lastX = shapeX;
        lastY = shapeY;
      end
    end
  end

  initial begin
    hostIf.iHostValid = 1'b0;
    hostIf.iHostX     = 10'd0;
    hostIf.iHostY     = 10'd0;
    repeat (3) @(negedge iClk);
    checkOutput("resetReady", hostIf.oHostReady, 0);
    checkOutput("resetX", shapeX, 290);
    checkOutput("resetY", shapeY, 210);
    checkOutput("shapeSize", shapeSize, 60);
    iRstN     = 1'b1;
    monitorOn = 1'b1;
    @(negedge iClk);
    checkOutput("firstReady", hostIf.oHostReady, HostEn);
    repeat (19) @(negedge iClk);
    checkOutput("idleX", shapeX, 290);
    checkOutput("idleY", shapeY, 210);
    checkOutput("idleGrant0", grant, 0);
    checkLeds("idleLeds0", 0);

    holdManual(1'b1, 1'b0, 1'b0, 1'b1, 3);
    checkOutput("upRightX", shapeX, 290);
    checkOutput("upRightY", shapeY, 207);

`ifdef SHAPE_SCHED_HOST_EN
    hostLoad(700, 5);
    checkOutput("clampX", shapeX, 580);
    checkOutput("clampY", shapeY, 5);
    saverRun(2);
    checkOutput("bounceX", shapeX, 578);
    checkOutput("bounceY", shapeY, 7);
    hostLoad(0, 0);
`else
    hostAttempt(700, 5);
    saverRun(2);
    checkOutput("saverX", shapeX, 292);
    checkOutput("saverY", shapeY, 209);
    holdManual(1'b1, 1'b0, 1'b0, 1'b0, modelY);
    holdManual(1'b0, 1'b0, 1'b1, 1'b0, modelX);
`endif
    holdManual(1'b1, 1'b0, 1'b1, 1'b0, 3);
    checkOutput("cornerX", shapeX, 0);
    checkOutput("cornerY", shapeY, 0);

`ifdef SHAPE_SCHED_HOST_EN
    hostLoad(579, 419);
`else
    holdManual(1'b0, 1'b0, 1'b0, 1'b1, 579);
    holdManual(1'b0, 1'b1, 1'b0, 1'b0, 419);
`endif
    saverRun(2);
    checkOutput("edgeBounceX", shapeX, 579);
    checkOutput("edgeBounceY", shapeY, 419);

    holdManual(1'b0, 1'b0, 1'b0, 1'b1, 3);
    checkOutput("rightLimitX", shapeX, 580);
    holdManual(1'b0, 1'b1, 1'b0, 1'b0, 2);
    checkOutput("downLimitY", shapeY, 420);

    // Async reset mid-interval while the saver is running.
    modelDirX = 1'b1;
    modelDirY = 1'b1;
    saverModelStep();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    waitSteps(1);
    @(posedge iClk);
    #3;
    pushExp(290, 210);
    iRstN = 1'b0;
    #1;
    checkOutput("asyncResetX", shapeX, 290);
    checkOutput("asyncResetY", shapeY, 210);
    checkOutput("asyncResetGrant", grant, 0);
    checkLeds("asyncResetLeds", 0);
    checkOutput("asyncResetReady", hostIf.oHostReady, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge iClk);
    checkOutput("queueEmpty", expQ.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
